// File: rtl/mtc_builder_buffered.sv
// MTC builder with per-slot FIFO buffering.
// Each SLC candidate slot is merged with the pT-calc result picked by its
// process channel, tagged with a processing flag, and queued toward the SL link.
module mtc_builder_buffered #(
  parameter int unsigned N_SLOT   = 3,
  parameter int unsigned N_PTCALC = 3,
  parameter int unsigned CH_W     = 2,
  parameter int unsigned COMMON_W = 64,
  parameter int unsigned PT_W     = 9,
  parameter int unsigned THR_W    = 4,
  parameter int unsigned NSEG_W   = 2,
  parameter int unsigned Q_W      = 4,
  parameter int unsigned SLID_W   = 5,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DROP_W   = 8,
  localparam int unsigned PKT_W   = COMMON_W + PT_W + THR_W + 1 + NSEG_W + Q_W + 4,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_srst,
  input  logic [N_SLOT-1:0]            i_slc_valid,
  input  logic [N_SLOT-1:0]            i_slc_busy,
  input  logic [N_SLOT*CH_W-1:0]       i_slc_proc_ch,
  input  logic [N_SLOT*3-1:0]          i_slc_cointype,
  input  logic [N_SLOT*THR_W-1:0]      i_slc_ptthresh,
  input  logic [N_SLOT*COMMON_W-1:0]   i_slc_common,
  input  logic [N_PTCALC*SLID_W-1:0]   i_pt_slid,
  input  logic [N_PTCALC*PT_W-1:0]     i_pt_pt,
  input  logic [N_PTCALC*THR_W-1:0]    i_pt_thr,
  input  logic [N_PTCALC-1:0]          i_pt_charge,
  input  logic [N_PTCALC*NSEG_W-1:0]   i_pt_nseg,
  input  logic [N_PTCALC*Q_W-1:0]      i_pt_quality,
  output logic [N_SLOT*PKT_W-1:0]      o_mtc_data,
  output logic [N_SLOT-1:0]            o_mtc_valid,
  input  logic [N_SLOT-1:0]            i_mtc_ready,
  output logic [N_SLOT*CNT_W-1:0]      o_fifo_count,
  output logic [N_SLOT*DROP_W-1:0]     o_drop_cnt,
  output logic [N_SLOT-1:0]            o_overflow
);

  localparam int unsigned MDT_W = PT_W + THR_W + 1 + NSEG_W + Q_W;

  for (genvar s = 0; s < N_SLOT; s++) begin : g_slot
    logic [CH_W-1:0]     w_ch;
    logic [2:0]          w_cointype;
    logic [THR_W-1:0]    w_ptthresh;
    logic                w_legal;
    logic [SLID_W-1:0]   w_sel_slid;
    logic [PT_W-1:0]     w_sel_pt;
    logic [THR_W-1:0]    w_sel_thr;
    logic                w_sel_charge;
    logic [NSEG_W-1:0]   w_sel_nseg;
    logic [Q_W-1:0]      w_sel_quality;
    logic [MDT_W-1:0]    w_mdt;
    logic [3:0]          w_flags;
    logic [PKT_W-1:0]    w_pkt;

    logic [PKT_W-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [DROP_W-1:0]   r_drop;
    logic                r_ovf;

    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    assign w_ch       = i_slc_proc_ch[s*CH_W +: CH_W];
    assign w_cointype = i_slc_cointype[s*3 +: 3];
    assign w_ptthresh = i_slc_ptthresh[s*THR_W +: THR_W];

    // Select the pT-calc result addressed by this slot's process channel.
    always_comb begin
      w_legal       = 1'b0;
      w_sel_slid    = '0;
      w_sel_pt      = '0;
      w_sel_thr     = '0;
      w_sel_charge  = 1'b0;
      w_sel_nseg    = '0;
      w_sel_quality = '0;
      for (int c = 0; c < int'(N_PTCALC); c++) begin
        if (32'(w_ch) == 32'(c)) begin
          w_legal       = 1'b1;
          w_sel_slid    = i_pt_slid[c*SLID_W +: SLID_W];
          w_sel_pt      = i_pt_pt[c*PT_W +: PT_W];
          w_sel_thr     = i_pt_thr[c*THR_W +: THR_W];
          w_sel_charge  = i_pt_charge[c];
          w_sel_nseg    = i_pt_nseg[c*NSEG_W +: NSEG_W];
          w_sel_quality = i_pt_quality[c*Q_W +: Q_W];
        end
      end
    end

    // Classify the candidate and mask MDT fields for busy/illegal channels.
    always_comb begin
      w_mdt   = '0;
      w_flags = 4'h0;
      if (i_slc_busy[s]) begin
        w_flags = 4'h0;
      end else if (!w_legal) begin
        w_flags = 4'hE;
      end else begin
        w_mdt = {w_sel_pt, w_sel_thr, w_sel_charge, w_sel_nseg, w_sel_quality};
        if (w_sel_slid != '0) begin
          w_flags = 4'h3;
        end else if (w_sel_pt != '0) begin
          w_flags = (w_sel_thr >= w_ptthresh) ? 4'h1 : 4'h2;
        end else if (w_cointype == 3'd0) begin
          if (w_sel_nseg == '0)                 w_flags = 4'h4;
          else if (32'(w_sel_nseg) == 32'd1)    w_flags = 4'h5;
          else                                  w_flags = 4'hF;
        end else begin
          w_flags = (32'(w_sel_nseg) > 32'd2) ? 4'h6 : 4'hF;
        end
      end
    end

    assign w_pkt = {i_slc_common[s*COMMON_W +: COMMON_W], w_mdt, w_flags};

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = !w_empty && i_mtc_ready[s];
    assign w_push  = i_slc_valid[s] && (!w_full || w_pop);
    assign w_drop  = i_slc_valid[s] && w_full && !w_pop;

    // FIFO storage; contents need no reset since the head is masked when empty.
    always_ff @(posedge clk) begin
      if (w_push && !i_srst) begin
        r_mem[r_wr_ptr] <= w_pkt;
      end
    end

    // Pointers, occupancy and overflow bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_drop   <= '0;
        r_ovf    <= 1'b0;
      end else if (i_srst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_drop   <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
        if (w_drop) begin
          r_ovf <= 1'b1;
          if (r_drop != {DROP_W{1'b1}}) r_drop <= r_drop + DROP_W'(1);
        end
      end
    end

    assign o_mtc_valid[s]                   = !w_empty;
    assign o_mtc_data[s*PKT_W +: PKT_W]     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_fifo_count[s*CNT_W +: CNT_W]   = r_count;
    assign o_drop_cnt[s*DROP_W +: DROP_W]   = r_drop;
    assign o_overflow[s]                    = r_ovf;
  end

endmodule

// File: tb/tb_mtc_builder_buffered.sv
// Self-checking bench for mtc_builder_buffered with a queue-based reference model.
module tb_mtc_builder_buffered;

  localparam int NS  = 3;
  localparam int NP  = 3;
  localparam int PKT = 88;
  localparam int DEP = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           srst;
  logic [2:0]     slc_valid, slc_busy;
  logic [5:0]     slc_proc_ch;
  logic [8:0]     slc_cointype;
  logic [11:0]    slc_ptthresh;
  logic [191:0]   slc_common;
  logic [14:0]    pt_slid;
  logic [26:0]    pt_pt;
  logic [11:0]    pt_thr;
  logic [2:0]     pt_charge;
  logic [5:0]     pt_nseg;
  logic [11:0]    pt_quality;
  logic [263:0]   mtc_data;
  logic [2:0]     mtc_valid;
  logic [2:0]     mtc_ready;
  logic [8:0]     fifo_count;
  logic [23:0]    drop_cnt;
  logic [2:0]     overflow;

  // Stimulus fields per slot / channel
  bit          v[NS], b[NS], rdy[NS];
  int          chv[NS], coin[NS], thr[NS];
  logic [63:0] cmn[NS];
  int          pslid[NP], ppt[NP], pthr[NP], pchg[NP], pns[NP], pq[NP];

  // Reference model state
  logic [PKT-1:0] mq [NS][$];
  int             mdrop[NS];
  bit             movf[NS];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mtc_builder_buffered dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_srst         (srst),
    .i_slc_valid    (slc_valid),
    .i_slc_busy     (slc_busy),
    .i_slc_proc_ch  (slc_proc_ch),
    .i_slc_cointype (slc_cointype),
    .i_slc_ptthresh (slc_ptthresh),
    .i_slc_common   (slc_common),
    .i_pt_slid      (pt_slid),
    .i_pt_pt        (pt_pt),
    .i_pt_thr       (pt_thr),
    .i_pt_charge    (pt_charge),
    .i_pt_nseg      (pt_nseg),
    .i_pt_quality   (pt_quality),
    .o_mtc_data     (mtc_data),
    .o_mtc_valid    (mtc_valid),
    .i_mtc_ready    (mtc_ready),
    .o_fifo_count   (fifo_count),
    .o_drop_cnt     (drop_cnt),
    .o_overflow     (overflow)
  );

  // Expected packet from the classification rules
  function automatic logic [PKT-1:0] model_pkt(int s);
    int c;
    int f;
    logic [19:0] mdt;
    c = chv[s];
    mdt = '0;
    f = 0;
    if (b[s]) f = 0;
    else if (c >= NP) f = 14;
    else begin
      mdt = {9'(ppt[c]), 4'(pthr[c]), 1'(pchg[c]), 2'(pns[c]), 4'(pq[c])};
      if (pslid[c] != 0)      f = 3;
      else if (ppt[c] != 0)   f = (pthr[c] >= thr[s]) ? 1 : 2;
      else if (coin[s] == 0)  f = (pns[c] == 0) ? 4 : (pns[c] == 1) ? 5 : 15;
      else                    f = (pns[c] > 2) ? 6 : 15;
    end
    return {cmn[s], mdt, 4'(f)};
  endfunction

  function automatic logic [PKT-1:0] exp_head(int s);
    if (mq[s].size() > 0) return mq[s][0];
    return '0;
  endfunction

  function automatic logic [PKT-1:0] dut_data(int s);
    return mtc_data[s*PKT +: PKT];
  endfunction

  task automatic clear_inputs();
    for (int s = 0; s < NS; s++) begin
      v[s] = 0; b[s] = 0; rdy[s] = 0; chv[s] = 0; coin[s] = 0; thr[s] = 0; cmn[s] = '0;
    end
    for (int c = 0; c < NP; c++) begin
      pslid[c] = 0; ppt[c] = 0; pthr[c] = 0; pchg[c] = 0; pns[c] = 0; pq[c] = 0;
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < NS; s++) begin
      mq[s].delete();
      mdrop[s] = 0;
      movf[s] = 0;
    end
  endtask

  task automatic drive();
    for (int s = 0; s < NS; s++) begin
      slc_valid[s]           = v[s];
      slc_busy[s]            = b[s];
      mtc_ready[s]           = rdy[s];
      slc_proc_ch[s*2 +: 2]  = 2'(chv[s]);
      slc_cointype[s*3 +: 3] = 3'(coin[s]);
      slc_ptthresh[s*4 +: 4] = 4'(thr[s]);
      slc_common[s*64 +: 64] = cmn[s];
    end
    for (int c = 0; c < NP; c++) begin
      pt_slid[c*5 +: 5]    = 5'(pslid[c]);
      pt_pt[c*9 +: 9]      = 9'(ppt[c]);
      pt_thr[c*4 +: 4]     = 4'(pthr[c]);
      pt_charge[c]         = 1'(pchg[c]);
      pt_nseg[c*2 +: 2]    = 2'(pns[c]);
      pt_quality[c*4 +: 4] = 4'(pq[c]);
    end
  endtask

  // Apply inputs, advance the model by one edge, then step past the edge.
  task automatic tick();
    logic [PKT-1:0] p;
    bit pop, full;
    drive();
    for (int s = 0; s < NS; s++) begin
      p    = model_pkt(s);
      pop  = (mq[s].size() > 0) && rdy[s];
      full = (mq[s].size() == DEP);
      if (srst) begin
        mq[s].delete();
        mdrop[s] = 0;
        movf[s] = 0;
      end else begin
        if (pop) void'(mq[s].pop_front());
        if (v[s]) begin
          if (!full || pop) mq[s].push_back(p);
          else begin
            if (mdrop[s] < 255) mdrop[s]++;
            movf[s] = 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    srst  = 1'b0;
    clear_inputs();
    drive();
    model_clear();
    #3;
    tests++; if (mtc_valid !== 3'b000) begin fails++; $display("FAIL reset_valid got %b want 000", mtc_valid); end
    tests++; if (fifo_count !== 9'd0) begin fails++; $display("FAIL reset_count got %h want 0", fifo_count); end
    tests++; if (drop_cnt !== 24'd0) begin fails++; $display("FAIL reset_drop got %h want 0", drop_cnt); end
    tests++; if (overflow !== 3'b000) begin fails++; $display("FAIL reset_ovf got %b want 000", overflow); end
    tests++; if (mtc_data !== '0) begin fails++; $display("FAIL reset_data got %h want 0", mtc_data); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    clear_inputs();
    b[0] = 0; chv[0] = 1; ppt[1] = 100; pthr[1] = 5; thr[0] = 3; pslid[1] = 0;
    cmn[0] = 64'hDEAD_BEEF_0123_4567; v[0] = 1; rdy[0] = 0;
    tick();
    v[0] = 0;
    tests++; if (mtc_valid[0] !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", mtc_valid[0]); end
    tests++; if (mtc_data[3:0] !== 4'h1) begin fails++; $display("FAIL basic_flags got %h want 1", mtc_data[3:0]); end
    tests++; if (mtc_data[23:15] !== 9'd100) begin fails++; $display("FAIL basic_pt got %0d want 100", mtc_data[23:15]); end
    tests++; if (dut_data(0) !== exp_head(0)) begin fails++; $display("FAIL basic_pkt got %h want %h", dut_data(0), exp_head(0)); end
    rdy[0] = 1;
    tick();
    tests++; if (mtc_valid[0] !== 1'b0) begin fails++; $display("FAIL basic_pop got %b want 0", mtc_valid[0]); end
    tests++; if (dut_data(0) !== '0) begin fails++; $display("FAIL basic_empty_data got %h want 0", dut_data(0)); end
  endtask

  task automatic test_procflags();
    int expf[5];
    expf[0] = 3; expf[1] = 5; expf[2] = 6; expf[3] = 14; expf[4] = 0;
    clear_inputs();
    rdy[1] = 1;
    for (int i = 0; i < 5; i++) begin
      b[1] = 0; chv[1] = 2; coin[1] = 0; cmn[1] = {$urandom, $urandom};
      pslid[2] = 0; ppt[2] = 0; pns[2] = 0; pq[2] = 9; pthr[2] = 7; pchg[2] = 1;
      case (i)
        0: pslid[2] = 2;
        1: begin coin[1] = 0; pns[2] = 1; end
        2: begin coin[1] = 2; pns[2] = 3; end
        3: begin chv[1] = 3; ppt[2] = 77; end
        default: begin b[1] = 1; ppt[2] = 77; end
      endcase
      v[1] = 1;
      tick();
      tests++; if (32'(mtc_data[88 +: 4]) !== expf[i]) begin fails++; $display("FAIL procflag_%0d got %h want %h", i, mtc_data[88 +: 4], expf[i]); end
      tests++; if (dut_data(1) !== exp_head(1)) begin fails++; $display("FAIL procpkt_%0d got %h want %h", i, dut_data(1), exp_head(1)); end
      if (i >= 3) begin
        tests++; if (mtc_data[88+4 +: 20] !== 20'd0) begin fails++; $display("FAIL procmdt_%0d got %h want 0", i, mtc_data[88+4 +: 20]); end
      end
    end
    v[1] = 0;
    tick();
  endtask

  task automatic test_overflow();
    logic [PKT-1:0] sent[6];
    clear_inputs();
    rdy[2] = 0;
    for (int i = 0; i < 6; i++) begin
      cmn[2] = {$urandom, $urandom};
      ppt[0] = i + 1; chv[2] = 0;
      sent[i] = model_pkt(2);
      v[2] = 1;
      tick();
    end
    v[2] = 0;
    tests++; if (fifo_count[6 +: 3] !== 3'd4) begin fails++; $display("FAIL ovf_count got %0d want 4", fifo_count[6 +: 3]); end
    tests++; if (drop_cnt[16 +: 8] !== 8'd2) begin fails++; $display("FAIL ovf_drop got %0d want 2", drop_cnt[16 +: 8]); end
    tests++; if (overflow[2] !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", overflow[2]); end
    rdy[2] = 1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (dut_data(2) !== sent[i]) begin fails++; $display("FAIL ovf_order_%0d got %h want %h", i, dut_data(2), sent[i]); end
      tick();
    end
    tests++; if (mtc_valid[2] !== 1'b0) begin fails++; $display("FAIL ovf_drained got %b want 0", mtc_valid[2]); end
  endtask

  task automatic test_full_write_pop();
    logic [PKT-1:0] p;
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      cmn[0] = 64'(i + 16); v[0] = 1;
      tick();
    end
    cmn[0] = 64'hCAFE_F00D_5555_AAAA; p = model_pkt(0);
    v[0] = 1; rdy[0] = 1;
    tick();
    v[0] = 0;
    tests++; if (fifo_count[0 +: 3] !== 3'd4) begin fails++; $display("FAIL fwp_count got %0d want 4", fifo_count[0 +: 3]); end
    tests++; if (drop_cnt[0 +: 8] !== 8'd0) begin fails++; $display("FAIL fwp_drop got %0d want 0", drop_cnt[0 +: 8]); end
    tests++; if (overflow[0] !== 1'b0) begin fails++; $display("FAIL fwp_ovf got %b want 0", overflow[0]); end
    for (int i = 0; i < 3; i++) tick();
    tests++; if (dut_data(0) !== p) begin fails++; $display("FAIL fwp_last got %h want %h", dut_data(0), p); end
    tests++; if (fifo_count[0 +: 3] !== 3'd1) begin fails++; $display("FAIL fwp_tail_count got %0d want 1", fifo_count[0 +: 3]); end
    tick();
  endtask

  task automatic test_saturation();
    clear_inputs();
    v[1] = 1; rdy[1] = 0;
    for (int i = 0; i < 300; i++) begin
      cmn[1] = 64'(i);
      tick();
    end
    v[1] = 0;
    tests++; if (drop_cnt[8 +: 8] !== 8'd255) begin fails++; $display("FAIL sat_drop got %0d want 255", drop_cnt[8 +: 8]); end
    tests++; if (fifo_count[3 +: 3] !== 3'd4) begin fails++; $display("FAIL sat_count got %0d want 4", fifo_count[3 +: 3]); end
    tests++; if (overflow[1] !== 1'b1) begin fails++; $display("FAIL sat_ovf got %b want 1", overflow[1]); end
  endtask

  task automatic test_midstream_reset();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      cmn[0] = 64'(i + 100); v[0] = 1;
      tick();
    end
    v[0] = 0;
    tests++; if (fifo_count[0 +: 3] !== 3'd3) begin fails++; $display("FAIL mid_pre_count got %0d want 3", fifo_count[0 +: 3]); end
    rst_n = 1'b0;
    #1;
    model_clear();
    tests++; if (mtc_valid !== 3'b000) begin fails++; $display("FAIL arst_valid got %b want 000", mtc_valid); end
    tests++; if (fifo_count !== 9'd0) begin fails++; $display("FAIL arst_count got %h want 0", fifo_count); end
    tests++; if (drop_cnt !== 24'd0) begin fails++; $display("FAIL arst_drop got %h want 0", drop_cnt); end
    tests++; if (overflow !== 3'b000) begin fails++; $display("FAIL arst_ovf got %b want 000", overflow); end
    tests++; if (mtc_data !== '0) begin fails++; $display("FAIL arst_data got %h want 0", mtc_data); end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmn[0] = 64'(i + 200); v[0] = (i < 3); v[2] = 1;
      tick();
    end
    v[0] = 0; v[2] = 0;
    tests++; if (fifo_count[0 +: 3] !== 3'd3) begin fails++; $display("FAIL srst_pre_count got %0d want 3", fifo_count[0 +: 3]); end
    srst = 1'b1; v[0] = 1; rdy[0] = 1;
    tick();
    srst = 1'b0; v[0] = 0; rdy[0] = 0;
    tests++; if (mtc_valid !== 3'b000) begin fails++; $display("FAIL srst_valid got %b want 000", mtc_valid); end
    tests++; if (fifo_count !== 9'd0) begin fails++; $display("FAIL srst_count got %h want 0", fifo_count); end
    tests++; if (drop_cnt !== 24'd0) begin fails++; $display("FAIL srst_drop got %h want 0", drop_cnt); end
    tests++; if (overflow !== 3'b000) begin fails++; $display("FAIL srst_ovf got %b want 000", overflow); end
    tests++; if (mtc_data !== '0) begin fails++; $display("FAIL srst_data got %h want 0", mtc_data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      for (int s = 0; s < NS; s++) begin
        v[s]    = ($urandom_range(0, 3) != 0);
        rdy[s]  = ($urandom_range(0, 2) == 0);
        b[s]    = ($urandom_range(0, 3) == 0);
        chv[s]  = $urandom_range(0, 3);
        coin[s] = $urandom_range(0, 7);
        thr[s]  = $urandom_range(0, 15);
        cmn[s]  = {$urandom, $urandom};
      end
      for (int c = 0; c < NP; c++) begin
        pslid[c] = $urandom_range(0, 1) ? 0 : $urandom_range(0, 31);
        ppt[c]   = $urandom_range(0, 1) ? 0 : $urandom_range(0, 511);
        pthr[c]  = $urandom_range(0, 15);
        pchg[c]  = $urandom_range(0, 1);
        pns[c]   = $urandom_range(0, 3);
        pq[c]    = $urandom_range(0, 15);
      end
      srst = ($urandom_range(0, 59) == 0);
      tick();
      srst = 1'b0;
      for (int s = 0; s < NS; s++) begin
        tests++;
        if (mtc_valid[s] !== (mq[s].size() > 0)) begin fails++; $display("FAIL rnd_valid c%0d s%0d got %b want %0d", n, s, mtc_valid[s], mq[s].size() > 0); end
        tests++;
        if (dut_data(s) !== exp_head(s)) begin fails++; $display("FAIL rnd_data c%0d s%0d got %h want %h", n, s, dut_data(s), exp_head(s)); end
        tests++;
        if (32'(fifo_count[s*3 +: 3]) !== mq[s].size()) begin fails++; $display("FAIL rnd_count c%0d s%0d got %0d want %0d", n, s, fifo_count[s*3 +: 3], mq[s].size()); end
        tests++;
        if (32'(drop_cnt[s*8 +: 8]) !== mdrop[s]) begin fails++; $display("FAIL rnd_drop c%0d s%0d got %0d want %0d", n, s, drop_cnt[s*8 +: 8], mdrop[s]); end
        tests++;
        if (overflow[s] !== movf[s]) begin fails++; $display("FAIL rnd_ovf c%0d s%0d got %b want %b", n, s, overflow[s], movf[s]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_procflags();
    test_overflow();
    test_full_write_pop();
    test_saturation();
    test_midstream_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
